lsu_access_unit: RTL and testbench

Load/store access unit on the core side of the data-memory port. It accepts one load or store per handshake from the execute/memory stage and converts it into word-aligned accesses with byte enables. It splits accesses that cross a word boundary into two accesses, and merges, shifts and sign/zero-extends load data. It drives a word-wide synchronous memory with per-byte write strobes.

---
 rtl/lsu_access_unit.sv | 210 +++++++++++++++++++++
 tb/tb_lsu_access_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_access_unit.sv
// Load/store access unit: word-aligned memory accesses with byte enables, split of
// boundary-crossing accesses (when LSU_MISALIGN_SPLIT_EN is defined), load extract/extend.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | first word access
// ACC1  | second word access of a split request
// DATA  | capture last read word and build load result
// RESP  | one-cycle response
module lsu_access_unit #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            Funct3,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wd,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rd,
   output logic                  err,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic                  mem_rd,
   output logic [3:0]            mem_wr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam logic SPLIT_EN = 1'b1;
`else
   localparam logic SPLIT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_ACC0, S_ACC1, S_DATA, S_RESP
   } state_t;

   state_t state_q, state_d;

   logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic                  mem_rd_q, mem_rd_d;
   logic [3:0]            mem_wr_q, mem_wr_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  err_q, err_d;
   logic [DATA_W-1:0]     rd_q, rd_d;
   logic [DATA_W-1:0]     w0_q, w0_d;
   logic                  is_load_q, is_load_d;
   logic [2:0]            f3_q, f3_d;
   logic [1:0]            off_q, off_d;
   logic [3:0]            mask_hi_q, mask_hi_d;
   logic                  split_q, split_d;

   logic [7:0]          base_mask;
   logic [7:0]          lane_mask;
   logic                split_in;
   logic                illegal_in;
   logic [5:0]          sh_in;
   logic [DATA_W-1:0]   wdata_rot;
   logic [2*DATA_W-1:0] rd_pair;
   logic [DATA_W-1:0]   ld_sh;
   logic [DATA_W-1:0]   ld_ext;

   // Lanes touched by the request: low nibble is ACC0, high nibble spills into ACC1.
   always_comb begin
      case (Funct3[1:0])
         2'b00:   base_mask = 8'h01;
         2'b01:   base_mask = 8'h03;
         default: base_mask = 8'h0F;
      endcase
      lane_mask  = base_mask << addr[1:0];
      split_in   = |lane_mask[7:4];
      illegal_in = (MemRead == MemWrite) || (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11) ||
                   (MemWrite && Funct3[2]) || (split_in && !SPLIT_EN);
      sh_in      = {1'b0, addr[1:0], 3'b000};
      wdata_rot  = (wd << sh_in) | (wd >> (6'd32 - sh_in));
   end

   always_comb begin
      rd_pair = split_q ? {mem_rdata, w0_q} : {{DATA_W{1'b0}}, mem_rdata};
      ld_sh   = DATA_W'(rd_pair >> {off_q, 3'b000});
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
         3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
         3'b100:  ld_ext = {24'h0, ld_sh[7:0]};
         3'b101:  ld_ext = {16'h0, ld_sh[15:0]};
         default: ld_ext = ld_sh;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_rd_d    = 1'b0;
      mem_wr_d    = 4'b0000;
      rsp_valid_d = 1'b0;
      err_d       = err_q;
      rd_d        = rd_q;
      w0_d        = w0_q;
      is_load_d   = is_load_q;
      f3_d        = f3_q;
      off_d       = off_q;
      mask_hi_d   = mask_hi_q;
      split_d     = split_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               is_load_d   = MemRead;
               f3_d        = Funct3;
               off_d       = addr[1:0];
               mask_hi_d   = lane_mask[7:4];
               split_d     = split_in;
               mem_addr_d  = {addr[DM_ADDRESS-1:2], 2'b00};
               mem_wdata_d = wdata_rot;
               if (illegal_in) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  err_d       = 1'b1;
               end else begin
                  state_d = S_ACC0;
                  if (MemRead) mem_rd_d = 1'b1;
                  else         mem_wr_d = lane_mask[3:0];
               end
            end
         end
         S_ACC0: begin
            if (split_q) begin
               state_d    = S_ACC1;
               mem_addr_d = mem_addr_q + DM_ADDRESS'(4);
               if (is_load_q) mem_rd_d = 1'b1;
               else           mem_wr_d = mask_hi_q;
            end else if (is_load_q) begin
               state_d = S_DATA;
            end else begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               err_d       = 1'b0;
            end
         end
         S_ACC1: begin
            if (is_load_q) begin
               w0_d    = mem_rdata;
               state_d = S_DATA;
            end else begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               err_d       = 1'b0;
            end
         end
         S_DATA: begin
            rd_d        = ld_ext;
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b0;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 4'b0000;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;
         rd_q        <= '0;
         w0_q        <= '0;
         is_load_q   <= 1'b0;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
         mask_hi_q   <= 4'b0000;
         split_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         rsp_valid_q <= rsp_valid_d;
         err_q       <= err_d;
         rd_q        <= rd_d;
         w0_q        <= w0_d;
         is_load_q   <= is_load_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         mask_hi_q   <= mask_hi_d;
         split_q     <= split_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rd        = rd_q;
   assign err       = err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_access_unit.sv
// Directed bench for lsu_access_unit with a word-wide synchronous memory model.
// Split-access expectations follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_access_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [8:0]  addr;
   logic [31:0] wd;
   logic        rsp_valid, err;
   logic [31:0] rd;
   logic [8:0]  mem_addr;
   logic        mem_rd;
   logic [3:0]  mem_wr;
   logic [31:0] mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:127];

   int          lat;
   logic [8:0]  s_addr [0:1];
   logic [3:0]  s_wr   [0:1];
   logic [31:0] s_wd   [0:1];
   logic        s_rd   [0:1];
   logic        any_rd, any_wr, both, r_rsp, r_err;
   logic [31:0] r_rd;
   logic [31:0] keep;

   always #5 clk = ~clk;

   lsu_access_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3), .addr(addr), .wd(wd),
      .rsp_valid(rsp_valid), .rd(rd), .err(err), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr[8:2]];
      for (int k = 0; k < 4; k++)
         if (mem_wr[k]) mem[mem_addr[8:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] d);
      req_valid = 1'b1; MemRead = ld; MemWrite = st; Funct3 = f3; addr = a; wd = d;
      chk("req_ready_idle", 32'(req_ready), 32'h1);
      step();
      req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      lat = 1; any_rd = 1'b0; any_wr = 1'b0; both = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_addr[i] = '0; s_wr[i] = '0; s_wd[i] = '0; s_rd[i] = 1'b0;
      end
      for (int i = 0; i < 12; i++) begin
         if (i < 2) begin
            s_addr[i] = mem_addr; s_wr[i] = mem_wr; s_wd[i] = mem_wdata; s_rd[i] = mem_rd;
         end
         any_rd = any_rd | mem_rd;
         any_wr = any_wr | (|mem_wr);
         if (mem_rd && (|mem_wr)) both = 1'b1;
         if (rsp_valid) break;
         step();
         lat++;
      end
      r_rsp = rsp_valid; r_rd = rd; r_err = err;
      chk("rsp_seen", 32'(r_rsp), 32'h1);
      chk("rd_wr_overlap", 32'(both), 32'h0);
      step();
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      Funct3 = 3'b000; addr = '0; wd = '0;
      step(); step();
      reset = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_rd", rd, 32'h0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_rd", 32'(mem_rd), 32'h0);
      chk("rst_mem_wr", 32'(mem_wr), 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);

      // SW / LW aligned
      do_req(1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF);
      chk("sw_lat", 32'(lat), 32'd2);
      chk("sw_addr", 32'(s_addr[0]), 32'h010);
      chk("sw_wr", 32'(s_wr[0]), 32'hF);
      chk("sw_wdata", s_wd[0], 32'hDEADBEEF);
      chk("sw_err", 32'(r_err), 32'h0);
      chk("sw_mem", mem[4], 32'hDEADBEEF);
      do_req(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
      chk("lw_lat", 32'(lat), 32'd3);
      chk("lw_rd", r_rd, 32'hDEADBEEF);
      chk("lw_err", 32'(r_err), 32'h0);

      // byte/half stores and loads
      do_req(1'b0, 1'b1, 3'b000, 9'h013, 32'h000000A5);
      chk("sb_lat", 32'(lat), 32'd2);
      chk("sb_wr", 32'(s_wr[0]), 32'h8);
      chk("sb_lane3", 32'(s_wd[0][31:24]), 32'hA5);
      do_req(1'b1, 1'b0, 3'b000, 9'h013, 32'h0);
      chk("lb_rd", r_rd, 32'hFFFFFFA5);
      do_req(1'b1, 1'b0, 3'b100, 9'h013, 32'h0);
      chk("lbu_rd", r_rd, 32'h000000A5);
      do_req(1'b1, 1'b0, 3'b001, 9'h012, 32'h0);
      chk("lh_rd", r_rd, 32'hFFFFA5AD);
      do_req(1'b1, 1'b0, 3'b101, 9'h012, 32'h0);
      chk("lhu_rd", r_rd, 32'h0000A5AD);
      do_req(1'b0, 1'b1, 3'b000, 9'h016, 32'h0000007F);
      chk("sb_o2_wr", 32'(s_wr[0]), 32'h4);
      chk("sb_o2_wdata", s_wd[0], 32'h007F0000);

      do_req(1'b0, 1'b1, 3'b010, 9'h010, 32'h44332211);
      do_req(1'b0, 1'b1, 3'b010, 9'h014, 32'h88776655);
      chk("preload_hi", mem[5], 32'h88776655);

      // misaligned word load
      do_req(1'b1, 1'b0, 3'b010, 9'h012, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
      chk("lw_split_lat", 32'(lat), 32'd4);
      chk("lw_split_a0", 32'(s_addr[0]), 32'h010);
      chk("lw_split_a1", 32'(s_addr[1]), 32'h014);
      chk("lw_split_rd1", 32'(s_rd[1]), 32'h1);
      chk("lw_split_rd", r_rd, 32'h66554433);
      chk("lw_split_err", 32'(r_err), 32'h0);
`else
      chk("lw_mis_lat", 32'(lat), 32'd1);
      chk("lw_mis_err", 32'(r_err), 32'h1);
      chk("lw_mis_nord", 32'(any_rd), 32'h0);
`endif

      // half store at the top of the address space
      do_req(1'b0, 1'b1, 3'b001, 9'h1FF, 32'h0000BEEF);
`ifdef LSU_MISALIGN_SPLIT_EN
      chk("sh_wrap_lat", 32'(lat), 32'd3);
      chk("sh_wrap_a0", 32'(s_addr[0]), 32'h1FC);
      chk("sh_wrap_wr0", 32'(s_wr[0]), 32'h8);
      chk("sh_wrap_lane3", 32'(s_wd[0][31:24]), 32'hEF);
      chk("sh_wrap_a1", 32'(s_addr[1]), 32'h000);
      chk("sh_wrap_wr1", 32'(s_wr[1]), 32'h1);
      chk("sh_wrap_lane0", 32'(s_wd[1][7:0]), 32'hBE);
      chk("sh_wrap_mem0", 32'(mem[0][7:0]), 32'hBE);
`else
      chk("sh_mis_lat", 32'(lat), 32'd1);
      chk("sh_mis_err", 32'(r_err), 32'h1);
      chk("sh_mis_nowr", 32'(any_wr), 32'h0);
`endif

      // illegal requests
      do_req(1'b1, 1'b0, 3'b011, 9'h010, 32'h0);
      chk("ill_f3_lat", 32'(lat), 32'd1);
      chk("ill_f3_err", 32'(r_err), 32'h1);
      chk("ill_f3_nord", 32'(any_rd), 32'h0);
      do_req(1'b0, 1'b1, 3'b100, 9'h010, 32'h12345678);
      chk("ill_sbu_lat", 32'(lat), 32'd1);
      chk("ill_sbu_err", 32'(r_err), 32'h1);
      chk("ill_sbu_nowr", 32'(any_wr), 32'h0);
      chk("ill_sbu_mem", mem[4], 32'h44332211);
      do_req(1'b1, 1'b1, 3'b010, 9'h010, 32'h0);
      chk("ill_both_lat", 32'(lat), 32'd1);
      chk("ill_both_err", 32'(r_err), 32'h1);
      chk("ill_both_nostb", 32'(any_rd | any_wr), 32'h0);

      // legal loads after errors clear err
      do_req(1'b1, 1'b0, 3'b100, 9'h011, 32'h0);
      chk("lbu_o1_rd", r_rd, 32'h00000022);
      chk("lbu_o1_err", 32'(r_err), 32'h0);
      do_req(1'b1, 1'b0, 3'b001, 9'h016, 32'h0);
      chk("lh_o2_rd", r_rd, 32'hFFFF8877);

`ifdef LSU_MISALIGN_SPLIT_EN
      do_req(1'b0, 1'b1, 3'b010, 9'h021, 32'h11223344);
      chk("sw_split_lat", 32'(lat), 32'd3);
      chk("sw_split_wr0", 32'(s_wr[0]), 32'hE);
      chk("sw_split_wdata", s_wd[0], 32'h22334411);
      chk("sw_split_a1", 32'(s_addr[1]), 32'h024);
      chk("sw_split_wr1", 32'(s_wr[1]), 32'h1);
      addr = 9'h011;
`else
      addr = 9'h014;
`endif

      // reset during ACC0 drops the request
      keep = mem[5];
      req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b010; wd = 32'hAABBCCDD;
      step();
      req_valid = 1'b0; MemWrite = 1'b0;
      chk("rst_acc0_busy", 32'(req_ready), 32'h0);
      reset = 1'b1;
      step();
      chk("rst_acc0_ready", 32'(req_ready), 32'h1);
      chk("rst_acc0_wr", 32'(mem_wr), 32'h0);
      chk("rst_acc0_rsp", 32'(rsp_valid), 32'h0);
      reset = 1'b0;
      step();
      chk("rst_after_rsp", 32'(rsp_valid), 32'h0);
      chk("rst_after_wr", 32'(mem_wr), 32'h0);
      step();
`ifdef LSU_MISALIGN_SPLIT_EN
      chk("rst_word1_kept", mem[5], keep);
`else
      chk("rst_word1_kept", mem[5], 32'hAABBCCDD);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
